// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: opcodes, FSM states, access sizes, imm16 extension.
// Latency: none (declarations only).
// Backpressure: n/a.
package load_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_t;

  // imm16 -> 32-bit two's complement offset
  function automatic logic [31:0] sign_extend(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Data-memory read port: req/ack handshake carrying a word address and returned word.
// Latency: none (wiring only).
// Backpressure: requester holds mem_req and mem_addr until the memory asserts mem_ack.
interface load_unit_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/load_unit_align_extend.sv
// Selects the byte/half lane of a read word, extends it, and flags bad opcodes or alignment.
// Latency: combinational.
// Backpressure: none.
module load_align_extend
  import load_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        ea_lo,
  input  logic [5:0]        opcode,
  output logic [DATA_W-1:0] data,
  output logic              misalign,
  output logic              illegal
);

  size_t       size;
  logic        is_signed;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{ea_lo, 3'b000} +: 8];
  assign half_lane = rdata[{ea_lo[1], 4'b0000} +: 16];

  // Decode access size and signedness from the opcode
  always_comb begin
    size      = SZ_NONE;
    is_signed = 1'b0;
    case (opcode)
      OP_LB:  begin size = SZ_BYTE; is_signed = 1'b1; end
      OP_LBU: size = SZ_BYTE;
      OP_LH:  begin size = SZ_HALF; is_signed = 1'b1; end
      OP_LHU: size = SZ_HALF;
      OP_LW:  size = SZ_WORD;
      default: size = SZ_NONE;
    endcase
  end

  // Lane extraction, extension and fault flags
  always_comb begin
    data     = rdata;
    illegal  = (size == SZ_NONE);
    misalign = 1'b0;
    case (size)
      SZ_BYTE: data = {{(DATA_W-8){is_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: begin
        data     = {{(DATA_W-16){is_signed & half_lane[15]}}, half_lane};
        misalign = ea_lo[0];
      end
      SZ_WORD: misalign = (ea_lo != 2'b00);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// MIPS load execution (lb/lh/lw/lbu/lhu): EA = rs + simm16, memory read, align/extend, write-back.
// Latency: start sampled at edge N, ack in first REQ cycle -> done/reg_write in cycle N+2; +1 per wait.
// Backpressure: waits in REQ for mem_ack; start ignored while busy. Option LOAD_TIMEOUT_EN aborts stalled reads.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] Read_data1,
  output logic              busy,
  load_unit_if.master       mem,
  output logic              reg_write,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  logic [31:0]       ea_q, ea_d;
  logic [5:0]        op_q;
  logic [4:0]        rt_q;
  logic              fault_q;
  logic [DATA_W-1:0] ext_data;
  logic              misalign, illegal, bad_req;
  logic [1:0]        sel_lo;
  logic [5:0]        sel_op;
  logic              timeout_hit;
  logic              unused_instr;

  assign unused_instr = ^instruction[25:21];

  assign ea_d = Read_data1 + sign_extend(instruction[15:0]);

  // The checker sees the incoming instruction in IDLE and the captured one afterwards
  assign sel_lo  = (state_q == ST_IDLE) ? ea_d[1:0] : ea_q[1:0];
  assign sel_op  = (state_q == ST_IDLE) ? instruction[31:26] : op_q;
  assign bad_req = misalign | illegal;

  load_align_extend #(.DATA_W(DATA_W)) u_align (
    .rdata    (mem.mem_rdata),
    .ea_lo    (sel_lo),
    .opcode   (sel_op),
    .data     (ext_data),
    .misalign (misalign),
    .illegal  (illegal)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;

  // REQ cycle counter, cleared whenever a request is launched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  cnt_q <= '0;
    else if (state_q == ST_IDLE && start)        cnt_q <= '0;
    else if (state_q == ST_REQ && !mem.mem_ack)  cnt_q <= cnt_q + CW'(1);
  end

  assign timeout_hit = (state_q == ST_REQ) && !mem.mem_ack && (cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/strobe outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = bad_req ? ST_WB : ST_REQ;
      ST_REQ:  if (mem.mem_ack || timeout_hit) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign mem.mem_req  = (state_q == ST_REQ);
  assign mem.mem_addr = {ea_q[31:2], 2'b00};
  assign done         = (state_q == ST_WB);
  assign error        = done & fault_q;
  assign reg_write    = done & ~fault_q & (rt_q != 5'd0);

  // Request capture in IDLE and result capture on the way into WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ea_q       <= '0;
      op_q       <= '0;
      rt_q       <= '0;
      fault_q    <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        ea_q    <= ea_d;
        op_q    <= instruction[31:26];
        rt_q    <= instruction[20:16];
        fault_q <= bad_req;
        if (bad_req) write_reg <= instruction[20:16];
      end
      if (state_q == ST_REQ && mem.mem_ack) begin
        write_data <= ext_data;
        write_reg  <= rt_q;
      end else if (timeout_hit) begin
        fault_q   <= 1'b1;
        write_reg <= rt_q;
      end
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit: each scenario task drives and checks inline.
// Latency: samples on the falling edge; a zero-wait load shows done two samples after start.
// Backpressure: the bench plays memory and chooses how many cycles to withhold mem_ack.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] Read_data1;
  logic        busy, reg_write, done, error;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_unit_if #(.DATA_W(32)) mif ();

  load_unit #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .Read_data1  (Read_data1),
    .busy        (busy),
    .mem         (mif.master),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .done        (done),
    .error       (error)
  );

  // Present one start for exactly one rising edge; returns at the next falling edge
  task automatic issue(input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] rs, input logic [15:0] imm);
    @(negedge clk);
    instruction = {op, 5'd0, rt, imm};
    Read_data1  = rs;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; instruction = '0; Read_data1 = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, mif.mem_req, reg_write, done, error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {busy, mif.mem_req, reg_write, done, error}); end
    n_checks++; if ({mif.mem_addr, write_data, write_reg} !== 69'd0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h wd=%h wr=%0d expected all zero", mif.mem_addr, write_data, write_reg); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    issue(6'h23, 5'd5, 32'h100, 16'h0004);
    n_checks++; if ({busy, mif.mem_req, done} !== 3'b110) begin
      n_fail++; $display("FAIL lw_req: got busy/req/done=%b expected 110", {busy, mif.mem_req, done}); end
    n_checks++; if (mif.mem_addr !== 32'h104) begin
      n_fail++; $display("FAIL lw_addr: got %h expected 00000104", mif.mem_addr); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    n_checks++; if ({done, reg_write, error, mif.mem_req} !== 4'b1100) begin
      n_fail++; $display("FAIL lw_wb_strobes: got %b expected 1100", {done, reg_write, error, mif.mem_req}); end
    n_checks++; if (write_data !== 32'hDEADBEEF || write_reg !== 5'd5) begin
      n_fail++; $display("FAIL lw_wb_data: got %h r%0d expected deadbeef r5", write_data, write_reg); end
    @(negedge clk);
    n_checks++; if ({busy, done, reg_write} !== 3'b000 || write_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_after: got %b wd=%h expected 000 wd=deadbeef", {busy, done, reg_write}, write_data); end
  endtask

  task automatic test_byte();
    logic [5:0]  ops  [2] = '{6'h20, 6'h24};
    logic [31:0] exps [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 5'd7, 32'h200, 16'h0003);
      n_checks++; if (mif.mem_addr !== 32'h200 || mif.mem_req !== 1'b1) begin
        n_fail++; $display("FAIL byte_addr[%0d]: got %h req=%b expected 00000200 req=1", i, mif.mem_addr, mif.mem_req); end
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80000000;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      n_checks++; if (write_data !== exps[i] || reg_write !== 1'b1) begin
        n_fail++; $display("FAIL byte_data[%0d]: got %h we=%b expected %h we=1", i, write_data, reg_write, exps[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_half_wait();
    logic [5:0]  ops  [2] = '{6'h21, 6'h25};
    logic [31:0] exps [2] = '{32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 5'd9, 32'h10, 16'hFFFE);
      n_checks++; if (mif.mem_addr !== 32'h0C) begin
        n_fail++; $display("FAIL half_addr[%0d]: got %h expected 0000000c", i, mif.mem_addr); end
      // lhu takes two wait cycles: done must not appear early
      if (i == 1) begin
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_5678;
        for (int w = 0; w < 2; w++) begin
          mif.mem_ack = 1'b0;
          @(negedge clk);
          n_checks++; if ({mif.mem_req, done} !== 2'b10) begin
            n_fail++; $display("FAIL half_wait[%0d]: got req/done=%b expected 10", w, {mif.mem_req, done}); end
        end
      end
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h8001_0000;
      @(negedge clk);
      mif.mem_ack = 1'b0;
      n_checks++; if (write_data !== exps[i] || done !== 1'b1 || write_reg !== 5'd9) begin
        n_fail++; $display("FAIL half_data[%0d]: got %h done=%b r%0d expected %h done=1 r9", i, write_data, done, write_reg, exps[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_fault();
    logic [5:0]  ops [2] = '{6'h23, 6'h22};
    logic [15:0] imm [2] = '{16'h0002, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 5'd3, 32'h100, imm[i]);
      n_checks++; if ({mif.mem_req, done, error, reg_write} !== 4'b0110) begin
        n_fail++; $display("FAIL fault[%0d]: got req/done/err/we=%b expected 0110", i, {mif.mem_req, done, error, reg_write}); end
      @(negedge clk);
      n_checks++; if ({busy, done, error} !== 3'b000) begin
        n_fail++; $display("FAIL fault_after[%0d]: got %b expected 000", i, {busy, done, error}); end
    end
  endtask

  task automatic test_reset_mid();
    issue(6'h23, 5'd4, 32'h300, 16'h0008);
    repeat (3) @(negedge clk);
    n_checks++; if (mif.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got req=%b expected 1", mif.mem_req); end
    reset = 1'b0;
    #1;
    n_checks++; if (mif.mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got req=%b busy=%b expected 0 0", mif.mem_req, busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy, mif.mem_req, done, error, reg_write} !== 5'b0 || {mif.mem_addr, write_data, write_reg} !== 69'd0) begin
      n_fail++; $display("FAIL rst_mid_idle: got ctl=%b addr=%h wd=%h expected all zero", {busy, mif.mem_req, done, error, reg_write}, mif.mem_addr, write_data); end
  endtask

  task automatic test_rt0_busy_start();
    int pulses = 0;
    // ack while idle must not start anything
    mif.mem_ack = 1'b1;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    n_checks++; if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL idle_ack: got busy/done=%b expected 00", {busy, done}); end
    issue(6'h23, 5'd0, 32'h40, 16'h0000);
    instruction = {6'h23, 5'd0, 5'd6, 16'h0000}; Read_data1 = 32'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (mif.mem_addr !== 32'h40 || mif.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL busy_start_addr: got %h req=%b expected 00000040 req=1", mif.mem_addr, mif.mem_req); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mif.mem_ack = 1'b0;
      if (done) pulses++;
      if (c == 0) begin
        n_checks++; if ({done, reg_write, error} !== 3'b100) begin
          n_fail++; $display("FAIL rt0_wb: got done/we/err=%b expected 100", {done, reg_write, error}); end
      end
    end
    n_checks++; if (pulses !== 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rt0_pulses: got %0d busy=%b expected 1 busy=0", pulses, busy); end
  endtask

`ifdef LOAD_TIMEOUT_EN
  task automatic test_timeout();
    int seen = 0;
    issue(6'h23, 5'd8, 32'h500, 16'h0000);
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      if (done) seen = c;
      else @(negedge clk);
    end
    // REQ occupies samples 1..16, the fault WB appears at sample 17
    n_checks++; if (seen !== 17 || error !== 1'b1 || reg_write !== 1'b0) begin
      n_fail++; $display("FAIL timeout: got done at %0d err=%b we=%b expected 17 err=1 we=0", seen, error, reg_write); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_byte();
    test_half_wait();
    test_fault();
    test_reset_mid();
    test_rt0_busy_start();
`ifdef LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
